mkio_tx_encoder: RTL and testbench
==================================

// Module: mkio_tx_encoder
// PURPOSE
//  Manchester-II bi-phase word transmitter for the MKIO remote-terminal (RT) path.
//  Consumes the device TX interface (tx_data/tx_cd/tx_ready, returns tx_busy) and
//  serialises each 16-bit word onto the differential bus-driver pins.
//  Each word is 3-bit-time sync, 16 data bits MSB first and an odd parity bit: 20 bit times, 40 half-bit slots.
// PARAMETERS
//  HALF_BIT_CLKS  25  clk cycles per half-bit (50 MHz clk -> 1 Mbit/s); legal range >= 2
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  tx_data      in   16  word to send; sampled in the tx_ready rising-edge cycle
//  tx_cd        in   1   0 = command/status sync, 1 = data sync; sampled with tx_data
//  tx_ready     in   1   send request; level held >=1 clk, only the rising edge counts
//  tx_busy      out  1   high = a new request will not be accepted
//  line_p       out  1   bus driver, true phase
//  line_n       out  1   bus driver, complement phase
//  tx_en        out  1   driver enable; high while any slot is on the line
//  tx_overrun   out  1   1-clk pulse when a tx_ready edge arrives while tx_busy is high
// BEHAVIOUR
//  - Reset: state IDLE; line_p=line_n=tx_en=tx_busy=tx_overrun=0; dividers and slot counter cleared; holding register empty.
//    Reset mid-word aborts at once: the line goes quiescent the next cycle, no partial parity.
//  - Edge detection: accept = tx_ready & ~tx_ready_q, where tx_ready_q is registered with reset value 0.
//    If tx_busy=1 in that cycle, the request is dropped and tx_overrun pulses.
//  - Encoding: parity P = ~^tx_data (odd parity over the 16 data bits).
//    Bit 1 = high then low; bit 0 = low then high.
//    Sync for tx_cd=0 = 3 half-bits high then 3 low; sync for tx_cd=1 = 3 low then 3 high.
//  - Line: line_n = ~line_p while tx_en=1; line_p = line_n = 0 while tx_en=0.
//  - FSM states: IDLE, SYNC (slots 0-5), DATA (slots 6-37), PAR (slots 38-39).
//    IDLE -> SYNC on accept (or on a pending held word); SYNC -> DATA after slot 5; DATA -> PAR after slot 37.
//    PAR -> SYNC after slot 39 if a word is pending; otherwise PAR -> IDLE.
//  - Divider: counts 0..HALF_BIT_CLKS-1; the slot counter advances on the terminal count. Each slot is exactly HALF_BIT_CLKS clocks.
//  - Latency: an accept at edge N drives slot 0 on the pins from edge N+1.
//    A word occupies 40*HALF_BIT_CLKS clocks; the default is 1000 clk = 20 us.
//  - tx_busy rises at edge N+1, the same edge on which slot 0 appears, so an upstream poll 2+ clocks after its pulse always sees it.
//  - Simultaneous end-of-word and accept (idle variant): the word ends, tx_busy drops, and the request in that same cycle is still rejected.
// CONFIGURATION
//  MKIO_TX_PREFETCH_EN defined:
//    - One-word holding register is added; tx_busy = hold_full.
//    - A word accepted while the shifter is active waits in the holding register.
//      It starts on the clock after slot 39 ends, with no dead time, giving contiguous status+data frames.
//    - A second word while hold_full is an overrun.
//    - tx_en stays high across back-to-back words.
//  MKIO_TX_PREFETCH_EN undefined:
//    - No holding register; tx_busy = (state != IDLE).
//    - Consecutive words are separated by at least 1 idle clk (tx_en low).
// TESTING (HALF_BIT_CLKS=2 unless noted)
//  1) tx_data=16'h0800, tx_cd=0 -> slots HHHLLL, then 0000_1000_0000_0000 Manchester, P=0 (LH).
//     tx_busy high for 80 clk; line_n = ~line_p throughout.
//  2) 16'hFFFF, tx_cd=1 -> sync LLLHHH, 16x(HL), P=1 (HL).
//     Then 16'h0000 -> 16x(LH), P=1.
//  3) Prefetch: status word, then a data word 3 clk later -> second sync starts the clk after slot 39.
//     tx_en never drops; a third request while hold_full -> tx_overrun pulse, word not sent.
//  4) No prefetch: a request mid-word -> tx_overrun=1 for 1 clk, the line is unaffected.
//     A request after tx_busy falls is sent normally.
//  5) tx_ready held high 5 clk -> exactly one word sent.
//     Assert reset at slot 20 -> the next clk has line_p=line_n=tx_en=tx_busy=0, and a fresh word then sends correctly.
//  6) HALF_BIT_CLKS=25 -> each slot is 25 clk and the word is 1000 clk from the first line change to tx_en fall.

Source files
------------

// File: rtl/mkio_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mkio_tx_encoder                                                 |
// | Purpose  : Manchester-II bi-phase word transmitter for the MKIO RT path.   |
// |            Each word goes out as 3 bit-times of sync, 16 data bits MSB     |
// |            first and an odd parity bit: 40 half-bit slots per word.        |
// | Options  : MKIO_TX_PREFETCH_EN adds a one-word holding register so a word  |
// |            accepted during transmission follows with no dead time.         |
// | Params   : HALF_BIT_CLKS  clk cycles per half-bit slot (>= 2)              |
// | Ports    : clk         system clock                                        |
// |            reset       asynchronous, active-high reset                     |
// |            tx_data     word to send, sampled on the tx_ready rising edge   |
// |            tx_cd       0 = command/status sync, 1 = data sync              |
// |            tx_ready    send request (rising edge only)                     |
// |            tx_busy     a new request will not be accepted                  |
// |            line_p      bus driver, true phase                              |
// |            line_n      bus driver, complement phase                        |
// |            tx_en       driver enable                                       |
// |            tx_overrun  1-clk pulse when a request is dropped               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mkio_tx_encoder #(
  parameter int HALF_BIT_CLKS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  output logic        tx_busy,
  output logic        line_p,
  output logic        line_n,
  output logic        tx_en,
  output logic        tx_overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_PAR  = 2'd3;

  localparam int               DIV_W    = $clog2(HALF_BIT_CLKS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BIT_CLKS - 1);

  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic [5:0]       slot;
  logic [16:0]      shreg;      // {data, parity}; bit 16 is the bit on the line
  logic             cd_r;
  logic             tx_ready_q;

  logic             accept;
  logic             tc;
  logic             active;
  logic             word_end;
  logic             start;
  logic             reject;
  logic [15:0]      start_data;
  logic             start_cd;
  logic             level;

  assign accept   = tx_ready & ~tx_ready_q;
  assign tc       = (div == DIV_LAST);
  assign active   = (state != S_IDLE);
  assign word_end = (state == S_PAR) && tc && (slot == 6'd39);

`ifdef MKIO_TX_PREFETCH_EN
  logic        hold_full;
  logic [15:0] hold_data;
  logic        hold_cd;
  logic        take_direct;
  logic        take_hold;
  logic        start_hold;

  assign tx_busy     = hold_full;
  assign reject      = accept & hold_full;
  assign take_direct = accept & ~hold_full & ~active;
  assign take_hold   = accept & ~hold_full & active;
  // A held word launches on the edge that closes slot 39, so the next sync
  // slot follows the parity slot without a gap.
  assign start_hold  = hold_full & (~active | word_end);
  assign start       = start_hold | take_direct;
  assign start_data  = start_hold ? hold_data : tx_data;
  assign start_cd    = start_hold ? hold_cd   : tx_cd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 16'h0000;
      hold_cd   <= 1'b0;
    end else if (take_hold) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
      hold_cd   <= tx_cd;
    end else if (start_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  logic busy_r;

  // busy is a registered copy of "shifter active": it rises together with
  // slot 0 on the pins and falls together with tx_en, so the cycle right
  // after the last slot still rejects a request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= active;
    end
  end

  assign tx_busy    = busy_r;
  assign reject     = accept & (busy_r | active);
  assign start      = accept & ~busy_r & ~active;
  assign start_data = tx_data;
  assign start_cd   = tx_cd;
`endif

  // Half-bit level for the current slot. Data/parity slots pair up as
  // (even = bit value, odd = complement) from slot 6 on.
  always_comb begin
    level = 1'b0;
    case (state)
      S_SYNC:         level = (slot < 6'd3) ? ~cd_r : cd_r;
      S_DATA, S_PAR:  level = slot[0] ? ~shreg[16] : shreg[16];
      default:        level = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      div        <= '0;
      slot       <= 6'd0;
      shreg      <= 17'd0;
      cd_r       <= 1'b0;
      tx_ready_q <= 1'b0;
      tx_overrun <= 1'b0;
      tx_en      <= 1'b0;
      line_p     <= 1'b0;
      line_n     <= 1'b0;
    end else begin
      tx_ready_q <= tx_ready;
      tx_overrun <= reject;

      // Pins are a registered image of the slot state, one clock behind it.
      tx_en  <= active;
      line_p <= active & level;
      line_n <= active & ~level;

      if (start) begin
        state <= S_SYNC;
        div   <= '0;
        slot  <= 6'd0;
        cd_r  <= start_cd;
        shreg <= {start_data, ~^start_data};
      end else if (active) begin
        if (tc) begin
          div <= '0;
          // Move the next bit up after the second half of each bit cell.
          if ((slot >= 6'd6) && slot[0]) begin
            shreg <= {shreg[15:0], 1'b0};
          end
          if (slot == 6'd39) begin
            state <= S_IDLE;
            slot  <= 6'd0;
          end else begin
            slot <= slot + 6'd1;
            if (slot == 6'd5) begin
              state <= S_DATA;
            end else if (slot == 6'd37) begin
              state <= S_PAR;
            end
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mkio_tx_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mkio_tx_encoder                                              |
// | Purpose  : Self-checking bench for mkio_tx_encoder. Unit A runs with       |
// |            HALF_BIT_CLKS=2 for slot-exact checks, unit B with 25 for       |
// |            real-rate word timing. Honours MKIO_TX_PREFETCH_EN.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mkio_tx_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] a_data;
  logic        a_cd;
  logic        a_ready;
  logic        a_busy, a_p, a_n, a_en, a_ovr;
  logic [15:0] b_data;
  logic        b_cd;
  logic        b_ready;
  logic        b_busy, b_p, b_n, b_en, b_ovr;

  mkio_tx_encoder #(.HALF_BIT_CLKS(2)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_cd(a_cd), .tx_ready(a_ready),
    .tx_busy(a_busy), .line_p(a_p), .line_n(a_n), .tx_en(a_en), .tx_overrun(a_ovr)
  );

  mkio_tx_encoder #(.HALF_BIT_CLKS(25)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_cd(b_cd), .tx_ready(b_ready),
    .tx_busy(b_busy), .line_p(b_p), .line_n(b_n), .tx_en(b_en), .tx_overrun(b_ovr)
  );

`ifdef MKIO_TX_PREFETCH_EN
  localparam logic BUSY_SINGLE = 1'b0;  // busy only reflects the holding register
`else
  localparam logic BUSY_SINGLE = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] a_obs;
  assign a_obs = {27'd0, a_en, a_p, a_n, a_busy, a_ovr};

  typedef struct {
    logic [15:0] data;
    logic        cd;
    logic        par;   // hand-computed odd parity
    int          hold;  // clocks tx_ready stays high
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_level(input logic [15:0] d, input logic cd,
                                     input logic p, input int s);
    logic b;
    if (s < 6) begin
      return (s < 3) ? ~cd : cd;
    end else if (s < 38) begin
      b = d[15 - (s - 6) / 2];
      return (s % 2 == 0) ? b : ~b;
    end else begin
      return (s == 38) ? p : ~p;
    end
  endfunction

  function automatic logic [31:0] exp_vec(input logic en, input logic lvl,
                                          input logic busy, input logic ovr);
    return {27'd0, en, en & lvl, en & ~lvl, busy, ovr};
  endfunction

  // Starts a word on unit A from a sample point (#1 after a posedge) and
  // checks every clock of the word plus three idle clocks afterwards.
  // inject >= 0 pulses a second request after sample index inject.
  task automatic send_word(input logic [15:0] d, input logic cd, input logic p,
                           input int hold, input int inject, input string name);
    int t;
    logic en;
    logic lvl;
    a_data  = d;
    a_cd    = cd;
    a_ready = 1'b1;
    @(posedge clk); #1;
    t = 1;
    if (hold <= 1) a_ready = 1'b0;
    for (int k = 0; k < 83; k++) begin
      @(posedge clk); #1;
      t++;
      if (t == hold) a_ready = 1'b0;
      en  = (k < 80);
      lvl = en ? exp_level(d, cd, p, k / 2) : 1'b0;
      chk($sformatf("%s k=%0d", name, k), a_obs,
          exp_vec(en, lvl, en & BUSY_SINGLE, (inject >= 0) && (k == inject + 1)));
      if (inject >= 0 && k == inject)     a_ready = 1'b1;
      if (inject >= 0 && k == inject + 1) a_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int cnt;
    int bad;
    logic lvl;

    vecs[0] = '{16'h0800, 1'b0, 1'b0, 1};
    vecs[1] = '{16'hFFFF, 1'b1, 1'b1, 1};
    vecs[2] = '{16'h0000, 1'b1, 1'b1, 1};
    vecs[3] = '{16'hA5A5, 1'b1, 1'b1, 1};
    vecs[4] = '{16'h1234, 1'b0, 1'b0, 1};
    vecs[5] = '{16'h7FFF, 1'b0, 1'b0, 2};
    vecs[6] = '{16'h0001, 1'b1, 1'b0, 5};

    reset   = 1'b1;
    a_data  = 16'h0;
    a_cd    = 1'b0;
    a_ready = 1'b0;
    b_data  = 16'h0;
    b_cd    = 1'b0;
    b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset held", a_obs, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after reset", a_obs, 32'd0);

    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].data, vecs[i].cd, vecs[i].par, vecs[i].hold, -1,
                $sformatf("vec%0d", i));
    end

`ifdef MKIO_TX_PREFETCH_EN
    // Status word, data word three clocks later, third request while held.
    a_data = 16'h0800; a_cd = 1'b0; a_ready = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    for (int k = 0; k < 163; k++) begin
      logic en;
      @(posedge clk); #1;
      en  = (k < 160);
      lvl = !en ? 1'b0 :
            (k < 80) ? exp_level(16'h0800, 1'b0, 1'b0, k / 2)
                     : exp_level(16'hA5A5, 1'b1, 1'b1, (k - 80) / 2);
      chk($sformatf("prefetch k=%0d", k), a_obs,
          exp_vec(en, lvl, (k >= 2) && (k <= 78), k == 7));
      if (k == 1) begin a_data = 16'hA5A5; a_cd = 1'b1; a_ready = 1'b1; end
      if (k == 2) a_ready = 1'b0;
      if (k == 6) begin a_data = 16'hFFFF; a_cd = 1'b1; a_ready = 1'b1; end
      if (k == 7) a_ready = 1'b0;
    end
`else
    // Mid-word request is dropped with an overrun pulse, then one after busy falls goes out.
    send_word(16'h1234, 1'b0, 1'b0, 1, 20, "overrun");
    send_word(16'hA5A5, 1'b1, 1'b1, 1, -1, "after_busy");
`endif

    // Reset during slot 20 aborts the word; a fresh word then goes out cleanly.
    a_data = 16'h1234; a_cd = 1'b0; a_ready = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    chk("slot20 pre-reset", a_obs,
        exp_vec(1'b1, exp_level(16'h1234, 1'b0, 1'b0, 20), BUSY_SINGLE, 1'b0));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid-word reset", a_obs, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post reset idle", a_obs, 32'd0);
    send_word(16'h0800, 1'b0, 1'b0, 1, -1, "post_reset");

    // Real-rate unit: 25 clk slots, 1000 clk word.
    b_data = 16'h0800; b_cd = 1'b0; b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    waited = 0;
    while (!b_en && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("b first slot latency", 32'(waited), 32'd1);
    cnt = 0;
    bad = 0;
    while (b_en && cnt < 1100) begin
      lvl = exp_level(16'h0800, 1'b0, 1'b0, cnt / 25);
      if (b_p !== lvl || b_n !== ~lvl || b_busy !== BUSY_SINGLE) bad++;
      cnt++;
      @(posedge clk); #1;
    end
    chk("b word length", 32'(cnt), 32'd1000);
    chk("b slot errors", 32'(bad), 32'd0);
    chk("b idle after word", {28'd0, b_p, b_n, b_busy, b_ovr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
